// File: rtl/dp_pkg.sv
// Shared definitions for the dp_group sequencer: FSM state encoding and the
// {last,first} beat-flag codes presented on dp_group.in_valid.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } dp_state_t;

  localparam logic [1:0] IV_MID    = 2'b00;
  localparam logic [1:0] IV_FIRST  = 2'b01;
  localparam logic [1:0] IV_LAST   = 2'b10;
  localparam logic [1:0] IV_SINGLE = 2'b11;

  // Map the first/last beat qualifiers onto the in_valid code.
  function automatic logic [1:0] iv_flags(input logic first, input logic last);
    logic [1:0] iv;
    case ({last, first})
      2'b01:   iv = IV_FIRST;
      2'b10:   iv = IV_LAST;
      2'b11:   iv = IV_SINGLE;
      default: iv = IV_MID;
    endcase
    return iv;
  endfunction

endpackage

// File: rtl/dp_beat_cnt.sv
// Loadable up/down counter with a terminal-count compare; serves both as the
// operand beat counter and as the post-stream drain counter.
module dp_beat_cnt #(
  parameter int W    = 8,
  parameter bit DOWN = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_r;

  // Counter register: load has priority over stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (step) begin
      if (DOWN) begin
        count_r <= count_r - W'(1);
      end else begin
        count_r <= count_r + W'(1);
      end
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign tc    = (count_r == tc_val);

endmodule

// File: rtl/dp_group_seq.sv
// Sequencer in front of dp_group: takes a LEN-beat command, streams operand
// vectors into the lanes, waits out the unit latency and hands back the result.
module dp_group_seq
  import dp_pkg::*;
#(
  parameter int N_UNIT   = 32,
  parameter int DW_DATA  = 8,
  parameter int DW_LEN   = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [DW_LEN-1:0]         cmd_len,
  input  logic                      opd_valid,
  output logic                      opd_ready,
  input  logic [N_UNIT*DW_DATA-1:0] opd_a,
  input  logic [N_UNIT*DW_DATA-1:0] opd_b,
  output logic                      dp_enable,
  output logic [N_UNIT*DW_DATA-1:0] dp_in_a,
  output logic [N_UNIT*DW_DATA-1:0] dp_in_b,
  output logic [1:0]                dp_in_valid,
  input  logic [N_UNIT*DW_DATA-1:0] dp_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [N_UNIT*DW_DATA-1:0] res_data,
  output logic                      busy
);

  localparam int VW       = N_UNIT * DW_DATA;
  localparam int DW_DRAIN = $clog2(PIPE_LAT + 1);

  dp_state_t            state_r;
  dp_state_t            state_nxt_s;
  logic [DW_LEN-1:0]    len_r;
  logic [DW_LEN-1:0]    beat_cnt_s;
  logic [DW_LEN-1:0]    beat_tc_val_s;
  logic                 beat_tc_s;
  logic [DW_DRAIN-1:0]  drain_cnt_s;
  logic                 drain_tc_s;
  logic                 cmd_acc_s;
  logic                 beat_acc_s;
  logic                 beat_last_s;
  logic                 drain_done_s;
  logic                 res_hs_s;

  logic                 cmd_ready_r;
  logic                 opd_ready_r;
  logic                 busy_r;
  logic                 res_valid_r;
  logic                 dp_enable_r;
  logic [1:0]           dp_in_valid_r;
  logic [VW-1:0]        dp_in_a_r;
  logic [VW-1:0]        dp_in_b_r;
  logic [VW-1:0]        res_data_r;

  assign cmd_acc_s     = cmd_valid & (state_r == IDLE);
  assign beat_acc_s    = opd_valid & (state_r == RUN);
  assign beat_last_s   = beat_acc_s & beat_tc_s;
  assign drain_done_s  = (state_r == DRAIN) & drain_tc_s;
  assign res_hs_s      = res_ready & (state_r == HOLD);
  assign beat_tc_val_s = len_r - DW_LEN'(1);

  dp_beat_cnt #(.W(DW_LEN), .DOWN(1'b0)) u_beat_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cmd_acc_s),
    .load_val ({DW_LEN{1'b0}}),
    .step     (beat_acc_s & ~beat_tc_s),
    .tc_val   (beat_tc_val_s),
    .count    (beat_cnt_s),
    .tc       (beat_tc_s)
  );

  dp_beat_cnt #(.W(DW_DRAIN), .DOWN(1'b1)) u_drain_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (beat_last_s),
    .load_val (DW_DRAIN'(PIPE_LAT)),
    .step     ((state_r == DRAIN) & ~drain_tc_s),
    .tc_val   ({DW_DRAIN{1'b0}}),
    .count    (drain_cnt_s),
    .tc       (drain_tc_s)
  );

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_acc_s) state_nxt_s = RUN;
        else           state_nxt_s = IDLE;
      end
      RUN: begin
        if (beat_last_s) state_nxt_s = DRAIN;
        else             state_nxt_s = RUN;
      end
      DRAIN: begin
        if (drain_done_s) state_nxt_s = HOLD;
        else              state_nxt_s = DRAIN;
      end
      HOLD: begin
        if (res_hs_s) state_nxt_s = IDLE;
        else          state_nxt_s = HOLD;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, latched length, and handshake flags registered from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      len_r       <= DW_LEN'(1);
      cmd_ready_r <= 1'b1;
      opd_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      if (cmd_acc_s) begin
        len_r <= (cmd_len == {DW_LEN{1'b0}}) ? DW_LEN'(1) : cmd_len;
      end else begin
        len_r <= len_r;
      end
      cmd_ready_r <= (state_nxt_s == IDLE);
      opd_ready_r <= (state_nxt_s == RUN);
      busy_r      <= (state_nxt_s != IDLE);
      res_valid_r <= (state_nxt_s == HOLD);
    end
  end

  // Operand register stage toward dp_group and result capture; operands hold when idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_enable_r   <= 1'b0;
      dp_in_valid_r <= IV_MID;
      dp_in_a_r     <= {VW{1'b0}};
      dp_in_b_r     <= {VW{1'b0}};
      res_data_r    <= {VW{1'b0}};
    end else begin
      dp_enable_r <= beat_acc_s;
      if (beat_acc_s) begin
        dp_in_a_r     <= opd_a;
        dp_in_b_r     <= opd_b;
        dp_in_valid_r <= iv_flags(beat_cnt_s == {DW_LEN{1'b0}}, beat_tc_s);
      end else begin
        dp_in_a_r     <= dp_in_a_r;
        dp_in_b_r     <= dp_in_b_r;
        dp_in_valid_r <= IV_MID;
      end
      if (drain_done_s) begin
        res_data_r <= dp_out;
      end else begin
        res_data_r <= res_data_r;
      end
    end
  end

  assign cmd_ready   = cmd_ready_r;
  assign opd_ready   = opd_ready_r;
  assign busy        = busy_r;
  assign res_valid   = res_valid_r;
  assign dp_enable   = dp_enable_r;
  assign dp_in_valid = dp_in_valid_r;
  assign dp_in_a     = dp_in_a_r;
  assign dp_in_b     = dp_in_b_r;
  assign res_data    = res_data_r;

endmodule

// File: tb/tb_dp_group_seq.sv
// Self-checking bench for dp_group_seq with a behavioural 2-stage dp_group
// model and scoreboard queues for beats and results.
module tb_dp_group_seq;

  localparam int N_UNIT   = 32;
  localparam int DW_DATA  = 8;
  localparam int DW_LEN   = 8;
  localparam int PIPE_LAT = 2;
  localparam int VW       = N_UNIT * DW_DATA;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [DW_LEN-1:0] cmd_len = '0;
  logic              opd_valid = 1'b0;
  logic              opd_ready;
  logic [VW-1:0]     opd_a = '0;
  logic [VW-1:0]     opd_b = '0;
  logic              dp_enable;
  logic [VW-1:0]     dp_in_a;
  logic [VW-1:0]     dp_in_b;
  logic [1:0]        dp_in_valid;
  logic [VW-1:0]     dp_out = '0;
  logic              res_valid;
  logic              res_ready = 1'b1;
  logic [VW-1:0]     res_data;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int enable_cnt = 0;

  logic [1:0]    exp_iv_q[$];
  logic [VW-1:0] exp_a_q[$];
  logic [VW-1:0] exp_b_q[$];
  logic [VW-1:0] exp_res_q[$];
  logic [VW-1:0] last_en_a = '0;
  logic [VW-1:0] last_en_b = '0;
  logic [VW-1:0] acc_m = '0;

  dp_group_seq #(
    .N_UNIT(N_UNIT), .DW_DATA(DW_DATA), .DW_LEN(DW_LEN), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .opd_valid(opd_valid), .opd_ready(opd_ready), .opd_a(opd_a), .opd_b(opd_b),
    .dp_enable(dp_enable), .dp_in_a(dp_in_a), .dp_in_b(dp_in_b),
    .dp_in_valid(dp_in_valid), .dp_out(dp_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] mac(input logic [VW-1:0] acc, input logic [VW-1:0] a,
                                        input logic [VW-1:0] b, input bit first);
    logic [VW-1:0] r;
    logic [DW_DATA-1:0] p;
    for (int l = 0; l < N_UNIT; l++) begin
      p = a[l*DW_DATA +: DW_DATA] * b[l*DW_DATA +: DW_DATA];
      r[l*DW_DATA +: DW_DATA] = (first ? '0 : acc[l*DW_DATA +: DW_DATA]) + p;
    end
    return r;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int w = 0; w < VW / 32; w++) v[w*32 +: 32] = $urandom();
    return v;
  endfunction

  // dp_group model: accumulate on enabled beats, then one output register (2 cycles).
  always @(posedge clk) begin
    if (dp_enable) acc_m <= mac(acc_m, dp_in_a, dp_in_b, dp_in_valid[0]);
    dp_out <= acc_m;
  end

  // Scoreboard monitor: beats, idle-hold behaviour and results.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (dp_enable) begin
        enable_cnt++;
        if (exp_iv_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: dp_in_valid=%b with no beat expected", dp_in_valid);
        end else begin
          logic [1:0] eiv;
          logic [VW-1:0] ea, eb;
          eiv = exp_iv_q.pop_front();
          ea = exp_a_q.pop_front();
          eb = exp_b_q.pop_front();
          last_en_a = ea;
          last_en_b = eb;
          if (dp_in_valid !== eiv || dp_in_a !== ea || dp_in_b !== eb) begin
            errors++;
            $display("FAIL beat: dp_in_valid=%b required %b, a_ok=%0b b_ok=%0b",
                     dp_in_valid, eiv, dp_in_a === ea, dp_in_b === eb);
          end
        end
      end else begin
        if (dp_in_valid !== 2'b00 || dp_in_a !== last_en_a || dp_in_b !== last_en_b) begin
          errors++;
          $display("FAIL idle_hold: dp_in_valid=%b required 00, a_held=%0b b_held=%0b",
                   dp_in_valid, dp_in_a === last_en_a, dp_in_b === last_en_b);
        end
      end
      if (res_valid && res_ready) begin
        checks++;
        if (exp_res_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: res_data=%h", res_data[31:0]);
        end else begin
          logic [VW-1:0] er;
          er = exp_res_q.pop_front();
          if (res_data !== er) begin
            errors++;
            $display("FAIL result: res_data[31:0]=%h required %h", res_data[31:0], er[31:0]);
          end
        end
      end
    end
  end

  task automatic issue_cmd(input logic [DW_LEN-1:0] len);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_len = len;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL cmd_accept: cmd_ready stayed %b, required 1", cmd_ready);
    end
  endtask

  task automatic send_beats(input int len_eff, input int n_send, input int stall_k1,
                            input int stall_k2, input int stall_cyc);
    logic [VW-1:0] a, b, acc;
    bit ok;
    acc = '0;
    for (int k = 0; k < n_send; k++) begin
      if (k == stall_k1 || k == stall_k2) begin
        opd_valid = 1'b0;
        repeat (stall_cyc) begin
          @(posedge clk);
          #1;
        end
      end
      a = rand_vec();
      b = rand_vec();
      opd_a = a;
      opd_b = b;
      opd_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
        @(negedge clk);
        ok = opd_ready;
        @(posedge clk);
        #1;
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL beat_accept: beat %0d opd_ready=%b required 1", k, opd_ready);
        opd_valid = 1'b0;
        return;
      end
      exp_iv_q.push_back({k == len_eff - 1, k == 0});
      exp_a_q.push_back(a);
      exp_b_q.push_back(b);
      acc = mac(acc, a, b, k == 0);
      if (k == len_eff - 1) exp_res_q.push_back(acc);
    end
    opd_valid = 1'b0;
  endtask

  task automatic wait_result(input int exp_lat);
    int n = 0;
    bit seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      n = i;
      seen = res_valid;
    end
    checks++;
    if (!seen || n != exp_lat) begin
      errors++;
      $display("FAIL res_latency: res_valid after %0d cycles (seen=%0b) required %0d",
               n, seen, exp_lat);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cmd_ready, opd_ready, dp_enable, dp_in_valid, res_valid, busy} !== 7'b1000000) begin
      errors++;
      $display("FAIL reset_ctrl: {cr,or,en,iv,rv,busy}=%b required 1000000",
               {cmd_ready, opd_ready, dp_enable, dp_in_valid, res_valid, busy});
    end
    checks++;
    if (dp_in_a !== '0 || dp_in_b !== '0 || res_data !== '0) begin
      errors++;
      $display("FAIL reset_data: dp_in_a/b or res_data nonzero, required 0");
    end
    reset = 1'b0;
    opd_a = rand_vec();
    opd_valid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      checks++;
      if (opd_ready !== 1'b0 || dp_enable !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_opd_ignored: opd_ready=%b dp_enable=%b busy=%b required 0 0 0",
                 opd_ready, dp_enable, busy);
      end
    end
    opd_valid = 1'b0;
  endtask

  task automatic test_single();
    int e0;
    e0 = enable_cnt;
    issue_cmd(8'd1);
    send_beats(1, 1, -1, -1, 0);
    wait_result(PIPE_LAT + 1);
    @(posedge clk);
    #1;
    checks++;
    if (enable_cnt - e0 != 1 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single: enables=%0d cmd_ready=%b busy=%b required 1 1 0",
               enable_cnt - e0, cmd_ready, busy);
    end
  endtask

  task automatic test_stream(input int len, input int s1, input int s2, input int sc);
    int e0, c0;
    e0 = enable_cnt;
    issue_cmd(len[DW_LEN-1:0]);
    c0 = cyc;
    send_beats(len, len, s1, s2, sc);
    checks++;
    if (cyc - c0 != len + ((s1 >= 0) ? sc : 0) + ((s2 >= 0) ? sc : 0)) begin
      errors++;
      $display("FAIL stream_cycles: len=%0d took %0d cycles", len, cyc - c0);
    end
    wait_result(PIPE_LAT + 1);
    @(posedge clk);
    #1;
    checks++;
    if (enable_cnt - e0 != len || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL stream_enables: got %0d enables cmd_ready=%b required %0d 1",
               enable_cnt - e0, cmd_ready, len);
    end
  endtask

  task automatic test_hold();
    logic [VW-1:0] d;
    res_ready = 1'b0;
    issue_cmd(8'd3);
    send_beats(3, 3, -1, -1, 0);
    wait_result(PIPE_LAT + 1);
    d = res_data;
    cmd_valid = 1'b1;
    cmd_len = 8'd1;
    repeat (10) begin
      @(posedge clk);
      #1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== d || cmd_ready !== 1'b0 ||
          opd_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold: rv=%b data_stable=%0b cr=%b or=%b busy=%b required 1 1 0 0 1",
                 res_valid, res_data === d, cmd_ready, opd_ready, busy);
      end
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold_release: rv=%b cr=%b busy=%b required 0 1 0",
               res_valid, cmd_ready, busy);
    end
  endtask

  task automatic test_len_zero();
    int e0;
    e0 = enable_cnt;
    issue_cmd(8'd0);
    send_beats(1, 1, -1, -1, 0);
    wait_result(PIPE_LAT + 1);
    @(posedge clk);
    #1;
    checks++;
    if (enable_cnt - e0 != 1) begin
      errors++;
      $display("FAIL len_zero: enables=%0d required 1", enable_cnt - e0);
    end
  endtask

  task automatic test_reset_mid();
    issue_cmd(8'd4);
    send_beats(4, 2, -1, -1, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    exp_iv_q.delete();
    exp_a_q.delete();
    exp_b_q.delete();
    exp_res_q.delete();
    last_en_a = '0;
    last_en_b = '0;
    checks++;
    if ({cmd_ready, opd_ready, dp_enable, dp_in_valid, res_valid, busy} !== 7'b1000000 ||
        dp_in_a !== '0 || dp_in_b !== '0 || res_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: {cr,or,en,iv,rv,busy}=%b required 1000000, data_zero=%0b",
               {cmd_ready, opd_ready, dp_enable, dp_in_valid, res_valid, busy},
               (dp_in_a === '0) && (dp_in_b === '0) && (res_data === '0));
    end
    reset = 1'b0;
    test_stream(2, -1, -1, 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream(4, -1, -1, 0);
    test_stream(4, 2, 3, 3);
    test_hold();
    test_len_zero();
    test_reset_mid();
    test_stream(255, -1, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (exp_iv_q.size() != 0 || exp_res_q.size() != 0) begin
      errors++;
      $display("FAIL drain_queues: %0d beats and %0d results still expected",
               exp_iv_q.size(), exp_res_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
